// File: rtl/elixirchip_es1_spu_op_match_run_if.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_match_run_if
// Bundles the match-run block's sample input and result output so it can be
// chained behind the SPU match op.
//   s_match  : match flag from the upstream match op (1 = equal)
//   s_clear  : clears run, max and hit state
//   s_valid  : s_match is valid this cycle
//   m_run    : current consecutive-match count (COUNT_BITS)
//   m_max    : largest m_run since last clear or reset (COUNT_BITS)
//   m_hit    : one-result pulse when the run first reaches the threshold
//   m_valid  : outputs carry a new result this cycle
// Modports: slave = the match-run block, master = whoever feeds it and reads
// its results.
// -----------------------------------------------------------------------------
interface elixirchip_es1_spu_op_match_run_if #(
   parameter int COUNT_BITS = 8
) ();
   logic                  s_match;
   logic                  s_clear;
   logic                  s_valid;
   logic [COUNT_BITS-1:0] m_run;
   logic [COUNT_BITS-1:0] m_max;
   logic                  m_hit;
   logic                  m_valid;

   modport slave (
      input  s_match, s_clear, s_valid,
      output m_run, m_max, m_hit, m_valid
   );

   modport master (
      output s_match, s_clear, s_valid,
      input  m_run, m_max, m_hit, m_valid
   );
endinterface

// File: rtl/elixirchip_es1_spu_op_match_run.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_match_run
// Tracks a saturating consecutive-match run length, the maximum run since the
// last clear, and a one-shot hit when the run reaches THRESHOLD. Results leave
// through a LATENCY-deep, cke-gated, valid-qualified pipeline.
// Ports:
//   clk    : single clock
//   reset  : synchronous active-high reset (wins over cke)
//   cke    : clock enable; 0 freezes every register
//   io     : slave side of the match-run interface (s_* in, m_* out)
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_match_run #(
   parameter int    LATENCY    = 1,
   parameter int    COUNT_BITS = 8,
   parameter int    THRESHOLD  = 4,
   parameter string DEVICE     = "RTL",
   parameter string SIMULATION = "false",
   parameter string DEBUG      = "false"
) (
   input  logic clk,
   input  logic reset,
   input  logic cke,
   elixirchip_es1_spu_op_match_run_if.slave io
);

   localparam longint unsigned CNT_MAX = (64'd1 << COUNT_BITS) - 64'd1;
   // A threshold the counter can never represent disables the hit entirely.
   localparam bit                  THR_BAD = (64'(THRESHOLD) > CNT_MAX);
   localparam bit                  THR_EN  = (THRESHOLD != 0) && !THR_BAD;
   localparam bit [COUNT_BITS-1:0] THR_VAL = COUNT_BITS'(THRESHOLD);

   if (THR_BAD) begin : g_cfg_err
      $error("elixirchip_es1_spu_op_match_run: THRESHOLD exceeds counter range");
   end

   typedef struct packed {
      logic [COUNT_BITS-1:0] run;
      logic [COUNT_BITS-1:0] max;
      logic                  hit;
   } res_t;

   // Stage 0 is the compute stage; stage LATENCY-1 drives the outputs.
   res_t [LATENCY-1:0] res_q, res_d;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [COUNT_BITS-1:0] run_nx;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the if/else tree can leave it unassigned and infer a latch.
      res_d  = res_q;
      vld_d  = '0;
      run_nx = '0;

      if (io.s_clear) begin
         res_d[0] = '0;
         vld_d[0] = 1'b1;
      end else if (io.s_valid) begin
         if (io.s_match) begin
            // Saturate at all-ones instead of wrapping back to zero.
            run_nx = (res_q[0].run == '1) ? res_q[0].run : res_q[0].run + 1'b1;
         end
         res_d[0].run = run_nx;
         res_d[0].max = (run_nx > res_q[0].max) ? run_nx : res_q[0].max;
         // Fire only on the transition into THRESHOLD, so a run held at the
         // threshold by saturation does not re-trigger.
         res_d[0].hit = THR_EN && (run_nx == THR_VAL) && (res_q[0].run != THR_VAL);
         vld_d[0]     = 1'b1;
      end

      // Later stages capture data only behind a valid result, so outputs stay
      // at the last valid result while m_valid is low.
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) begin
            res_d[i] = res_q[i-1];
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every stage samples
   // its predecessor's pre-edge value and the pipeline shifts cleanly.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the data stages are reset too, not just the valid bits,
         // because the outputs must read zero straight out of reset.
         res_q <= '0;
         vld_q <= '0;
      end else if (cke) begin
         res_q <= res_d;
         vld_q <= vld_d;
      end
   end

   assign io.m_run   = res_q[LATENCY-1].run;
   assign io.m_max   = res_q[LATENCY-1].max;
   assign io.m_hit   = res_q[LATENCY-1].hit;
   assign io.m_valid = vld_q[LATENCY-1];

   if (DEBUG == "true" && SIMULATION == "true" && DEVICE != "") begin : g_dbg
      always_ff @(posedge clk) begin
         if (!reset) begin
            assert (res_q[0].max >= res_q[0].run);
         end
      end
   end

endmodule
